snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Central sequencer for the snake game. It takes one-cycle command pulses from the PS/2 key decoder and the collision checker, and owns the game state machine (idle/run/pause/dead). It also generates the movement tick that steps the snake datapath, and buffers up to two direction changes so that quick turns between ticks are not lost. Its outputs drive the position-update logic and the VGA renderer's start/death/escape flags.

## Interface
Parameters:
- TICK_DIV, 25000000: CLK cycles per movement tick (4 Hz at 100 MHz); legal range is 2 and above.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  start/restart pulse.
- ESC  in  1  escape pulse.
- PAUSE  in  1  pause pulse.
- RESUME  in  1  resume pulse.
- DIR_U, DIR_D, DIR_L, DIR_R  in  1 each  turn-request pulses.
- DEATH  in  1  collision pulse from the bounds/collision checker.
- TICK  out  1  one-cycle movement strobe.
- DIR  out  2  current heading: 0=R, 1=D, 2=L, 3=U.
- STATE  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DEAD.
- MOVE_EN  out  1  high iff STATE==RUN.
- START_FLAG, DEATH_FLAG, ESC_FLAG  out  1 each  renderer flags.
- Q_COUNT  out  2  turn-queue occupancy, 0–2.

## Operation
- Reset values:
  - STATE=IDLE, DIR=0 (R), TICK=0, MOVE_EN=0.
  - All flags 0, Q_COUNT=0, tick counter 0.
- When several command inputs pulse in the same cycle, only the highest-priority one acts. Priority: START > ESC > DEATH > PAUSE/RESUME > DIR_*. Lower-priority pulses in that cycle are dropped.
- START, accepted from any state:
  - STATE=RUN, DIR=R, queue flushed, counter=0.
  - START_FLAG=1, DEATH_FLAG=0, ESC_FLAG=0.
- ESC, accepted from any state:
  - STATE=IDLE, ESC_FLAG=1, START_FLAG=0, DEATH_FLAG=0, queue flushed.
- DEATH, honoured in RUN only:
  - STATE=DEAD, DEATH_FLAG=1, START_FLAG=0, queue flushed.
  - Ignored in all other states.
- PAUSE in RUN: STATE=PAUSE, counter frozen. RESUME in PAUSE: STATE=RUN, counter continues from its frozen value. Both are ignored in all other states.
- Turn requests, accepted in RUN only:
  - If several DIR_* pulse together, priority is U > D > L > R.
  - The candidate turn is compared against the tail: the last queued entry, or DIR if the queue is empty.
  - The turn is enqueued only if it is perpendicular to the tail (bit 0 differs) and Q_COUNT < 2. Otherwise it is dropped.
  - Same-axis and reverse requests are therefore never queued.
- Movement tick:
  - In RUN, the counter increments every cycle.
  - At count TICK_DIV-1, TICK=1 for that cycle and the counter wraps to 0.
  - In the same cycle, if the queue is non-empty, the head is popped into DIR.

## Timing
- All outputs are registered. Each command takes effect on the CLK edge where its pulse is sampled; STATE, DIR and the flags are visible in the following cycle.
- TICK is a combinational compare of the registered counter gated by STATE==RUN, so it is high for exactly one cycle per TICK_DIV cycles. In a run started cleanly by START, the first TICK occurs TICK_DIV cycles after the START edge.
- DIR updated by a tick pop is visible the cycle after TICK. The datapath therefore moves using the DIR value present during the TICK cycle.
- Events coinciding with a tick:
  - DEATH in the same cycle as a tick count: the death transition happens, no pop occurs, and the counter resets. TICK still pulses, so the datapath must qualify movement with MOVE_EN.
  - PAUSE coinciding with a tick: the tick and pop complete, then STATE becomes PAUSE.
  - Enqueue and pop in the same cycle: both happen, and Q_COUNT is unchanged. If the queue was empty, the new entry is checked against the pre-pop DIR.
- RST mid-run returns all state to reset values immediately (asynchronously). A START pulse coincident with RST deassertion is ignored.
- Counter width is clog2(TICK_DIV) bits and is never compared against values of TICK_DIV or above.

## Structure
- Package snake_pkg holds:
  - the STATE encoding (IDLE/RUN/PAUSE/DEAD);
  - the DIR encoding (R/D/L/U) and a perpendicular-check function;
  - the default TICK_DIV.
- Sub-module snake_dir_queue: a 2-entry FIFO with push/pop/flush, head, tail and count. It is shared later with the two-player variant.

## Test plan
All scenarios use TICK_DIV=4.
- Reset then START: STATE=1, DIR=0, START_FLAG=1; TICK pulses at cycles 4, 8, 12 after the START edge, with MOVE_EN=1.
- Quick double turn in RUN: DIR_D then DIR_L between ticks gives Q_COUNT=2. The next TICK sets DIR=1, the following TICK sets DIR=2, and Q_COUNT ends at 0.
- Rejections while heading R with an empty queue:
  - DIR_L and DIR_R are both dropped (Q_COUNT stays 0).
  - A third perpendicular request when Q_COUNT=2 is dropped.
- PAUSE after 2 counter cycles, held 10 cycles, then RESUME: no TICK during the pause; the next TICK comes 2 cycles after RESUME.
- DEATH asserted in the tick cycle with Q_COUNT=1: STATE=3, DEATH_FLAG=1, START_FLAG=0, DIR unchanged, Q_COUNT=0. A later DIR_U is ignored; a later START restores STATE=1 and DIR=0.
- START and ESC in the same cycle: START wins (STATE=1, ESC_FLAG=0). A lone ESC then gives STATE=0 and ESC_FLAG=1; RST mid-run clears all outputs.

Source files
------------

// File: rtl/snake_pkg.sv
// +----------------------------------------------------------------------+
// | snake_pkg: shared state/heading encodings and movement-rate default  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package snake_pkg;

   localparam int TICK_DIV_DEFAULT = 25000000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DEAD  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      D_R = 2'd0,
      D_D = 2'd1,
      D_L = 2'd2,
      D_U = 2'd3
   } dir_t;

   // Horizontal headings have bit 0 clear, vertical ones set.
   function automatic logic is_perp(dir_t a, dir_t b);
      return a[0] ^ b[0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/snake_game_ctrl_if.sv
// +----------------------------------------------------------------------+
// | snake_game_ctrl_if: command pulses in, game status/strobes out       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface snake_game_ctrl_if;
   logic       START;
   logic       ESC;
   logic       PAUSE;
   logic       RESUME;
   logic       DIR_U;
   logic       DIR_D;
   logic       DIR_L;
   logic       DIR_R;
   logic       DEATH;
   logic       TICK;
   logic [1:0] DIR;
   logic [1:0] STATE;
   logic       MOVE_EN;
   logic       START_FLAG;
   logic       DEATH_FLAG;
   logic       ESC_FLAG;
   logic [1:0] Q_COUNT;

   modport master (
      output START, ESC, PAUSE, RESUME, DIR_U, DIR_D, DIR_L, DIR_R, DEATH,
      input  TICK, DIR, STATE, MOVE_EN, START_FLAG, DEATH_FLAG, ESC_FLAG, Q_COUNT
   );

   modport slave (
      input  START, ESC, PAUSE, RESUME, DIR_U, DIR_D, DIR_L, DIR_R, DEATH,
      output TICK, DIR, STATE, MOVE_EN, START_FLAG, DEATH_FLAG, ESC_FLAG, Q_COUNT
   );
endinterface

`default_nettype wire

// File: rtl/snake_dir_queue.sv
// +----------------------------------------------------------------------+
// | snake_dir_queue: 2-entry heading FIFO with push/pop/flush            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module snake_dir_queue
   import snake_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       push,
   input  wire dir_t       push_dir,
   input  wire logic       pop,
   input  wire logic       flush,
   output dir_t            head,
   output dir_t            tail,
   output logic [1:0]      count
);

   dir_t       e0_q, e0_d;
   dir_t       e1_q, e1_d;
   logic [1:0] cnt_q, cnt_d;
   logic       w_pop;
   logic       w_push;

   // A pop from empty is meaningless; a push into a full queue is only
   // legal when the same cycle frees the head slot.
   assign w_pop  = pop && (cnt_q != 2'd0);
   assign w_push = push && ((cnt_q != 2'd2) || w_pop);

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (cnt_q == 2'd0) e0_d = push_dir;
               else               e1_d = push_dir;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               e0_d  = e1_q;
               cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd2) begin
                  e0_d = e1_q;
                  e1_d = push_dir;
               end else begin
                  e0_d = push_dir;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0_q  <= D_R;
         e1_q  <= D_R;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = e0_q;
   assign tail  = (cnt_q == 2'd2) ? e1_q : e0_q;
   assign count = cnt_q;

endmodule

`default_nettype wire

// File: rtl/snake_game_ctrl.sv
// +----------------------------------------------------------------------+
// | snake_game_ctrl: game FSM, movement tick and buffered turn requests  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
)(
   input  wire logic         CLK,
   input  wire logic         RST,
   snake_game_ctrl_if.slave  bus
);

   localparam int            CW     = $clog2(TICK_DIV);
   localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

   state_t        state_q, state_d;
   dir_t          dir_q, dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sflag_q, sflag_d;
   logic          dflag_q, dflag_d;
   logic          eflag_q, eflag_d;
   logic          move_en_q, move_en_d;

   logic          q_push, q_pop, q_flush;
   dir_t          q_head, q_tail;
   logic [1:0]    q_count;

   logic          w_run;
   logic          w_tick;
   logic          w_turn;
   dir_t          w_cand;
   dir_t          w_tail_ref;

   assign w_run      = (state_q == ST_RUN);
   assign w_tick     = w_run && (cnt_q == C_LAST);
   assign w_turn     = bus.DIR_U | bus.DIR_D | bus.DIR_L | bus.DIR_R;
   assign w_cand     = bus.DIR_U ? D_U : bus.DIR_D ? D_D : bus.DIR_L ? D_L : D_R;
   assign w_tail_ref = (q_count == 2'd0) ? dir_q : q_tail;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      sflag_d = sflag_q;
      dflag_d = dflag_q;
      eflag_d = eflag_q;
      q_push  = 1'b0;
      q_pop   = 1'b0;
      q_flush = 1'b0;

      if (bus.START) begin
         state_d = ST_RUN;
         dir_d   = D_R;
         cnt_d   = '0;
         q_flush = 1'b1;
         sflag_d = 1'b1;
         dflag_d = 1'b0;
         eflag_d = 1'b0;
      end else if (bus.ESC) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         q_flush = 1'b1;
         sflag_d = 1'b0;
         dflag_d = 1'b0;
         eflag_d = 1'b1;
      end else if (bus.DEATH) begin
         // A death on the tick count still resets the counter without popping.
         if (w_run) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            q_flush = 1'b1;
            sflag_d = 1'b0;
            dflag_d = 1'b1;
         end
      end else begin
         if (w_run) begin
            if (w_tick) begin
               cnt_d = '0;
               if (q_count != 2'd0) begin
                  q_pop = 1'b1;
                  dir_d = q_head;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         if (bus.PAUSE || bus.RESUME) begin
            if (bus.PAUSE && w_run)
               state_d = ST_PAUSE;
            else if (bus.RESUME && (state_q == ST_PAUSE))
               state_d = ST_RUN;
         end else if (w_turn && w_run && is_perp(w_cand, w_tail_ref)
                      && (q_count != 2'd2)) begin
            q_push = 1'b1;
         end
      end

      move_en_d = (state_d == ST_RUN);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         dir_q     <= D_R;
         cnt_q     <= '0;
         sflag_q   <= 1'b0;
         dflag_q   <= 1'b0;
         eflag_q   <= 1'b0;
         move_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         sflag_q   <= sflag_d;
         dflag_q   <= dflag_d;
         eflag_q   <= eflag_d;
         move_en_q <= move_en_d;
      end
   end

   snake_dir_queue u_queue (
      .clk      (CLK),
      .rst      (RST),
      .push     (q_push),
      .push_dir (w_cand),
      .pop      (q_pop),
      .flush    (q_flush),
      .head     (q_head),
      .tail     (q_tail),
      .count    (q_count)
   );

   assign bus.TICK       = w_tick;
   assign bus.DIR        = dir_q;
   assign bus.STATE      = state_q;
   assign bus.MOVE_EN    = move_en_q;
   assign bus.START_FLAG = sflag_q;
   assign bus.DEATH_FLAG = dflag_q;
   assign bus.ESC_FLAG   = eflag_q;
   assign bus.Q_COUNT    = q_count;

endmodule

`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_snake_game_ctrl: directed and random bench for snake_game_ctrl    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_snake_game_ctrl;

   localparam int TD = 4;

   localparam logic [8:0] C_NONE  = 9'h000;
   localparam logic [8:0] C_START = 9'h100;
   localparam logic [8:0] C_ESC   = 9'h080;
   localparam logic [8:0] C_DEATH = 9'h040;
   localparam logic [8:0] C_PAUSE = 9'h020;
   localparam logic [8:0] C_RES   = 9'h010;
   localparam logic [8:0] C_U     = 9'h008;
   localparam logic [8:0] C_D     = 9'h004;
   localparam logic [8:0] C_L     = 9'h002;
   localparam logic [8:0] C_R     = 9'h001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   snake_game_ctrl_if bus ();

   snake_game_ctrl #(.TICK_DIV(TD)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // Reference model: state/heading as integers, the turn buffer as a queue.
   int m_state, m_dir, m_cnt;
   int m_q[$];
   bit m_sf, m_df, m_ef;

   task automatic model_reset();
      m_state = 0; m_dir = 0; m_cnt = 0;
      m_q.delete();
      m_sf = 0; m_df = 0; m_ef = 0;
   endtask

   task automatic model_step(input logic [8:0] c);
      bit st, es, de, pa, re, u, d, l, r, run, tk, do_push;
      int cand, tail;
      {st, es, de, pa, re, u, d, l, r} = c;
      run = (m_state == 1);
      tk  = run && (m_cnt == TD - 1);
      do_push = 0;
      cand = 0;
      if (st) begin
         m_state = 1; m_dir = 0; m_cnt = 0; m_q.delete();
         m_sf = 1; m_df = 0; m_ef = 0;
      end else if (es) begin
         m_state = 0; m_q.delete(); m_ef = 1; m_sf = 0; m_df = 0; m_cnt = 0;
      end else if (de) begin
         if (run) begin
            m_state = 3; m_q.delete(); m_df = 1; m_sf = 0; m_cnt = 0;
         end
      end else begin
         if (!(pa || re) && (u || d || l || r) && run) begin
            cand = u ? 3 : d ? 1 : l ? 2 : 0;
            tail = (m_q.size() > 0) ? m_q[$] : m_dir;
            do_push = ((cand % 2) != (tail % 2)) && (m_q.size() < 2);
         end
         if (run) begin
            if (tk) begin
               m_cnt = 0;
               if (m_q.size() > 0) m_dir = m_q.pop_front();
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
         if (pa && run) m_state = 2;
         else if (re && !pa && m_state == 2) m_state = 1;
         else if (re && pa && m_state == 2) m_state = 1;
         if (do_push) m_q.push_back(cand);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, 32'(bus.STATE), 32'(m_state));
      chk({tag, ".dir"},   32'(bus.DIR),   32'(m_dir));
      chk({tag, ".tick"},  32'(bus.TICK),  32'(m_state == 1 && m_cnt == TD - 1));
      chk({tag, ".move"},  32'(bus.MOVE_EN), 32'(m_state == 1));
      chk({tag, ".sflag"}, 32'(bus.START_FLAG), 32'(m_sf));
      chk({tag, ".dflag"}, 32'(bus.DEATH_FLAG), 32'(m_df));
      chk({tag, ".eflag"}, 32'(bus.ESC_FLAG),   32'(m_ef));
      chk({tag, ".qcnt"},  32'(bus.Q_COUNT),    32'(m_q.size()));
   endtask

   task automatic drive(input logic [8:0] c);
      {bus.START, bus.ESC, bus.DEATH, bus.PAUSE, bus.RESUME,
       bus.DIR_U, bus.DIR_D, bus.DIR_L, bus.DIR_R} = c;
   endtask

   // Entered 1 time unit after a rising edge; returns at the same phase.
   task automatic cyc(input logic [8:0] c, input string tag, output logic t);
      drive(c);
      #1;
      t = bus.TICK;
      check_all(tag);
      model_step(c);
      @(posedge clk);
      #1;
      drive(C_NONE);
   endtask

   initial begin
      logic t;
      logic [8:0] c;
      int r;

      drive(C_NONE);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.state", 32'(bus.STATE), 32'd0);
      rst = 1'b0;

      // Clean start and tick cadence
      cyc(C_START, "start", t);
      chk("start.state", 32'(bus.STATE), 32'd1);
      chk("start.sflag", 32'(bus.START_FLAG), 32'd1);
      for (int k = 1; k <= 12; k++) begin
         cyc(C_NONE, "cadence", t);
         chk($sformatf("cadence.tick%0d", k), 32'(t), 32'(k % 4 == 0));
      end

      // Quick double turn between ticks
      cyc(C_D, "dbl", t);
      cyc(C_L, "dbl", t);
      chk("dbl.q2", 32'(bus.Q_COUNT), 32'd2);
      cyc(C_NONE, "dbl", t);
      cyc(C_NONE, "dbl", t);
      chk("dbl.dir1", 32'(bus.DIR), 32'd1);
      repeat (4) cyc(C_NONE, "dbl", t);
      chk("dbl.dir2", 32'(bus.DIR), 32'd2);
      chk("dbl.q0", 32'(bus.Q_COUNT), 32'd0);

      // Same-axis / reverse rejection and full-queue rejection
      cyc(C_START, "rej", t);
      cyc(C_L, "rej", t);
      cyc(C_R, "rej", t);
      chk("rej.axis_q0", 32'(bus.Q_COUNT), 32'd0);
      cyc(C_NONE, "rej", t);
      cyc(C_NONE, "rej", t);
      cyc(C_D, "rej", t);
      cyc(C_L, "rej", t);
      cyc(C_U, "rej", t);
      chk("rej.full_q2", 32'(bus.Q_COUNT), 32'd2);

      // Pause freezes the counter
      cyc(C_START, "pause", t);
      cyc(C_NONE, "pause", t);
      cyc(C_PAUSE, "pause", t);
      chk("pause.state", 32'(bus.STATE), 32'd2);
      for (int k = 0; k < 10; k++) begin
         cyc(C_NONE, "pause", t);
         chk("pause.notick", 32'(t), 32'd0);
      end
      cyc(C_RES, "resume", t);
      cyc(C_NONE, "resume", t);
      chk("resume.r1", 32'(t), 32'd0);
      cyc(C_NONE, "resume", t);
      chk("resume.r2", 32'(t), 32'd1);

      // Death on the tick cycle with one queued turn
      cyc(C_START, "death", t);
      cyc(C_D, "death", t);
      cyc(C_NONE, "death", t);
      cyc(C_NONE, "death", t);
      chk("death.q1", 32'(bus.Q_COUNT), 32'd1);
      cyc(C_DEATH, "death", t);
      chk("death.tick", 32'(t), 32'd1);
      chk("death.state", 32'(bus.STATE), 32'd3);
      chk("death.dflag", 32'(bus.DEATH_FLAG), 32'd1);
      chk("death.sflag", 32'(bus.START_FLAG), 32'd0);
      chk("death.dir", 32'(bus.DIR), 32'd0);
      chk("death.q0", 32'(bus.Q_COUNT), 32'd0);
      cyc(C_U, "dead_turn", t);
      chk("dead_turn.q0", 32'(bus.Q_COUNT), 32'd0);
      cyc(C_START, "restart", t);
      chk("restart.state", 32'(bus.STATE), 32'd1);

      // Priority between START and ESC, then lone ESC
      cyc(C_START | C_ESC, "prio", t);
      chk("prio.state", 32'(bus.STATE), 32'd1);
      chk("prio.eflag", 32'(bus.ESC_FLAG), 32'd0);
      cyc(C_ESC, "esc", t);
      chk("esc.state", 32'(bus.STATE), 32'd0);
      chk("esc.eflag", 32'(bus.ESC_FLAG), 32'd1);

      // Randomized command mix
      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(0, 99));
         c = C_NONE;
         if (r < 4)       c |= C_START;
         else if (r < 6)  c |= C_ESC;
         else if (r < 10) c |= C_DEATH;
         else if (r < 16) c |= C_PAUSE;
         else if (r < 26) c |= C_RES;
         if ($urandom_range(0, 9) < 2) c |= C_U;
         if ($urandom_range(0, 9) < 2) c |= C_D;
         if ($urandom_range(0, 9) < 2) c |= C_L;
         if ($urandom_range(0, 9) < 2) c |= C_R;
         cyc(c, "rand", t);
      end

      // Asynchronous reset mid-run, START held through reset release
      cyc(C_START, "arst", t);
      cyc(C_D, "arst", t);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("arst");
      drive(C_START);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(C_NONE);
      check_all("rst_start");
      chk("rst_start.state", 32'(bus.STATE), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
